// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle shared by the instruction cache refill path and its memory.
//   master modport: drives AW/W/AR channel requests and B/R ready.
//   slave modport : drives channel ready signals and B/R responses.
interface axi_lite_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/icache_line.sv
// Direct-mapped, read-only instruction cache with line refill over AXI4-Lite.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flash          : invalidate all lines
//   valid, addr    : fetch request and word-aligned byte address
//   ready, rdata   : hit indication and instruction word (combinational, 0 on miss)
//   m_axi          : refill bus master (read channels only; write channels tied off)
//   hit_cnt,
//   miss_cnt       : hit/miss statistics, present only when ICACHE_STATS_EN is defined
// INIT_FILE is accepted for compatibility with preloaded builds; the data array is not
// reset and its contents are never visible until a refill has set the line valid bit.
module icache_line #(
    parameter int unsigned CACHE_SIZE = 4096,
    parameter int unsigned LINE_WORDS = 4,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flash,
    input  logic        valid,
    input  logic [31:0] addr,
    output logic        ready,
    output logic [31:0] rdata,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    axi_lite_if.master  m_axi
);

    localparam int unsigned OffW     = $clog2(LINE_WORDS);
    localparam int unsigned BeatW    = (OffW > 0) ? OffW : 1;
    localparam int unsigned NumLines = CACHE_SIZE / (4 * LINE_WORDS);
    localparam int unsigned IdxW     = $clog2(NumLines);
    localparam int unsigned IdxLsb   = OffW + 2;
    localparam int unsigned TagW     = 32 - IdxW - IdxLsb;
    localparam logic [31:0] LineMask = 32'(LINE_WORDS * 4 - 1);
    localparam bit          HasInit  = (INIT_FILE != "");

    typedef enum logic [1:0] {StIdle, StRaddr, StRdata, StAllocate} state_e;

    state_e              state_q, state_d;
    logic [BeatW-1:0]    beat_q;
    logic [31:0]         base_q;
    logic                flush_pend_q;
    logic [NumLines-1:0] line_valid_q;
    logic [TagW-1:0]     tag_q  [NumLines];
    logic [31:0]         data_q [NumLines][LINE_WORDS];

    logic [IdxW-1:0]  req_idx, base_idx;
    logic [TagW-1:0]  req_tag, base_tag;
    logic [BeatW-1:0] req_off;
    logic             line_match, hit, miss_start, last_beat, r_fire;

    assign req_idx  = addr[IdxLsb +: IdxW];
    assign req_tag  = addr[31 -: TagW];
    assign base_idx = base_q[IdxLsb +: IdxW];
    assign base_tag = base_q[31 -: TagW];

    if (OffW > 0) begin : g_off
        assign req_off = addr[2 +: BeatW];
    end else begin : g_no_off
        assign req_off = '0;
    end

    assign line_match = line_valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign hit        = valid && line_match && (state_q == StIdle) && !flash;
    assign miss_start = valid && !line_match && (state_q == StIdle) && !flash;
    assign last_beat  = (beat_q == BeatW'(LINE_WORDS - 1));
    assign r_fire     = (state_q == StRdata) && m_axi.rvalid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (miss_start) state_d = StRaddr;
            StRaddr:    if (m_axi.arready) state_d = StRdata;
            StRdata:    if (m_axi.rvalid) state_d = last_beat ? StAllocate : StRaddr;
            StAllocate: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        ready         = hit;
        rdata         = '0;
        m_axi.arvalid = 1'b0;
        m_axi.araddr  = '0;
        m_axi.rready  = 1'b0;
        if (hit) begin
            rdata = data_q[req_idx][req_off];
        end
        if (state_q == StRaddr) begin
            m_axi.arvalid = 1'b1;
            m_axi.araddr  = base_q + 32'({beat_q, 2'b00});
        end
        if (state_q == StRdata) begin
            m_axi.rready = 1'b1;
        end
    end

    // Write channels are never used by an instruction cache.
    assign m_axi.awvalid = 1'b0;
    assign m_axi.awaddr  = '0;
    assign m_axi.wvalid  = 1'b0;
    assign m_axi.wdata   = '0;
    assign m_axi.wstrb   = '0;
    assign m_axi.bready  = 1'b0;

    // Refill control and valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q       <= '0;
            base_q       <= '0;
            flush_pend_q <= 1'b0;
            line_valid_q <= '0;
        end else begin
            if (miss_start) begin
                base_q <= addr & ~LineMask;
            end
            if (state_q == StAllocate) begin
                beat_q <= '0;
            end else if (r_fire && !last_beat) begin
                beat_q <= beat_q + BeatW'(1);
            end
            if (state_q == StIdle) begin
                if (flash) begin
                    line_valid_q <= '0;
                end
            end else if (state_q == StAllocate) begin
                flush_pend_q <= 1'b0;
                // A flush seen anywhere in the refill (including now) leaves the line invalid.
                if (!flush_pend_q && !flash) begin
                    line_valid_q[base_idx] <= 1'b1;
                end
            end else if (flash) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

    // Data and tag arrays carry no reset; the valid bits gate every read.
    always_ff @(posedge clk) begin
        if (r_fire) begin
            data_q[base_idx][beat_q] <= m_axi.rdata;
        end
        if (state_q == StAllocate) begin
            tag_q[base_idx] <= base_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (flash) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{addr[1:0], m_axi.awready, m_axi.wready, m_axi.bvalid,
                             m_axi.bresp, m_axi.rresp, HasInit};

endmodule

// File: tb/tb_icache_line.sv
module tb_icache_line;

    logic        clk;
    logic        rst_n;
    logic        flash;
    logic        valid;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    axi_lite_if bus ();

    icache_line dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flash    (flash),
        .valid    (valid),
        .addr     (addr),
        .ready    (ready),
        .rdata    (rdata),
`ifdef ICACHE_STATS_EN
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
`endif
        .m_axi    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Memory image seen through the bus: each word is derived from its own address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory responder, acting on the falling edge so the DUT sees stable inputs.
    int          ar_delay = 0;
    int          r_delay  = 0;
    int          ar_cnt   = 0;
    int          r_cnt    = 0;
    int          stab_err = 0;
    logic        r_pend   = 1'b0;
    logic [31:0] ar_hold  = '0;
    logic [31:0] r_addr   = '0;
    logic [31:0] ar_log [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            bus.arready = 1'b0;
            bus.rvalid  = 1'b0;
            bus.rdata   = '0;
            r_pend      = 1'b0;
            ar_cnt      = 0;
            r_cnt       = 0;
        end else begin
            // A ready/valid raised last half-cycle was accepted on the rising edge.
            if (bus.arready) begin
                bus.arready = 1'b0;
                r_pend      = 1'b1;
                r_cnt       = 0;
            end else if (bus.rvalid) begin
                bus.rvalid = 1'b0;
            end
            if (bus.arvalid) begin
                if (ar_cnt == 0) ar_hold = bus.araddr;
                else if (bus.araddr !== ar_hold) stab_err++;
                if (ar_cnt >= ar_delay) begin
                    bus.arready = 1'b1;
                    ar_log.push_back(bus.araddr);
                    r_addr = bus.araddr;
                    ar_cnt = 0;
                end else begin
                    ar_cnt++;
                end
            end
            if (r_pend && bus.rready) begin
                if (r_cnt >= r_delay) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = memf(r_addr);
                    r_pend     = 1'b0;
                    r_cnt      = 0;
                end else begin
                    r_cnt++;
                end
            end
        end
    end

    // Request a word and wait for it; waits counts falling edges after the request.
    task automatic fetch(input logic [31:0] a, output int waits, output logic [31:0] data);
        @(negedge clk);
        valid = 1'b1;
        addr  = a;
        #1;
        waits = 0;
        while (!ready && waits < 300) begin
            @(negedge clk);
            #1;
            waits++;
        end
        data = rdata;
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          w;
        int          base_n;
        logic [31:0] d;

        rst_n       = 1'b0;
        flash       = 1'b0;
        valid       = 1'b0;
        addr        = '0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = '0;
        bus.rresp   = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
        chk("rst_rready", 32'(bus.rready), 32'd0);
        chk("rst_araddr", bus.araddr, 32'd0);
        chk("tie_valids", 32'({bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
        chk("tie_data", bus.awaddr | bus.wdata | 32'(bus.wstrb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss: one IDLE miss cycle, 2*4+1 refill cycles, then the hit.
        fetch(32'h100, w, d);
        chk("cold_wait", 32'(w), 32'd10);
        chk("cold_data", d, memf(32'h100));
        chk("cold_ar_n", 32'(ar_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("cold_araddr", ar_log[i], 32'h100 + 32'(4 * i));

        // Same-line hit: zero latency, no bus activity.
        fetch(32'h10C, w, d);
        chk("hit_wait", 32'(w), 32'd0);
        chk("hit_data", d, memf(32'h10C));
        chk("hit_arvalid", 32'(bus.arvalid), 32'd0);
        idle();
        chk("hit_ar_n", 32'(ar_log.size()), 32'd4);

        // Conflict: same index, different tag evicts the line.
        fetch(32'h1100, w, d);
        chk("conf_wait", 32'(w), 32'd10);
        chk("conf_data", d, memf(32'h1100));
        chk("conf_araddr", ar_log[4], 32'h1100);
        fetch(32'h100, w, d);
        chk("evict_wait", 32'(w), 32'd10);
        chk("evict_data", d, memf(32'h100));

        // Flash masks a would-be hit, then invalidates the line.
        @(negedge clk);
        valid = 1'b1;
        addr  = 32'h10C;
        flash = 1'b1;
        #1;
        chk("flash_ready", 32'(ready), 32'd0);
        chk("flash_rdata", rdata, 32'd0);
        @(negedge clk);
        flash = 1'b0;
        valid = 1'b0;
        fetch(32'h10C, w, d);
        chk("postflash_wait", 32'(w), 32'd10);
        chk("postflash_data", d, memf(32'h10C));

        // Backpressure: 5 AR wait states and 3 R wait states per beat.
        idle();
        base_n   = ar_log.size();
        ar_delay = 5;
        r_delay  = 3;
        fetch(32'h400, w, d);
        ar_delay = 0;
        r_delay  = 0;
        chk("bp_wait", 32'(w), 32'd42);
        chk("bp_data", d, memf(32'h400));
        chk("bp_ar_n", 32'(ar_log.size() - base_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_araddr", ar_log[base_n + i], 32'h400 + 32'(4 * i));
        end
        chk("bp_stable", 32'(stab_err), 32'd0);
        for (int i = 1; i < 4; i++) begin
            fetch(32'h400 + 32'(4 * i), w, d);
            chk("bp_line_wait", 32'(w), 32'd0);
            chk("bp_line_data", d, memf(32'h400 + 32'(4 * i)));
        end

        // Flush during beat 2: refill completes but the line stays invalid.
        idle();
        base_n = ar_log.size();
        @(negedge clk);
        valid = 1'b1;
        addr  = 32'h240;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 100 && ar_log.size() < base_n + 3; i++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        flash = 1'b1;
        @(negedge clk);
        flash = 1'b0;
        for (int i = 0; i < 100 && ar_log.size() < base_n + 4; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (4) @(negedge clk);
        #1;
        chk("fdr_ar_n", 32'(ar_log.size() - base_n), 32'd4);
        chk("fdr_idle", 32'({bus.arvalid, bus.rready}), 32'd0);
        fetch(32'h240, w, d);
        chk("fdr_rereq_wait", 32'(w), 32'd10);
        chk("fdr_rereq_data", d, memf(32'h240));

        // Reset while in RDATA abandons the refill.
        idle();
        base_n = ar_log.size();
        @(negedge clk);
        valid = 1'b1;
        addr  = 32'h300;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 100 && ar_log.size() < base_n + 2; i++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        chk("mid_rready", 32'(bus.rready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_bus", 32'({bus.arvalid, bus.rready}), 32'd0);
        chk("mid_rst_araddr", bus.araddr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fetch(32'h300, w, d);
        chk("mid_rereq_wait", 32'(w), 32'd10);
        chk("mid_rereq_data", d, memf(32'h300));
`ifdef ICACHE_STATS_EN
        fetch(32'h304, w, d);
        chk("st_hit1", 32'(w), 32'd0);
        fetch(32'h308, w, d);
        chk("st_hit2", 32'(w), 32'd0);
        idle();
        chk("st_miss_cnt", miss_cnt, 32'd1);
        chk("st_hit_cnt", hit_cnt, 32'd3);
`endif
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache_line.md
ICACHE_LINE -- requirements
Module: icache_line

Interface
REQ-001 SHALL have parameter CACHE_SIZE, default 4096, meaning total data capacity in bytes (power of two).
REQ-002 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per line (power of two, 1..16).
REQ-003 SHALL have parameter INIT_FILE, default "", meaning optional data-array preload file; valid bits still reset to 0.
REQ-004 SHALL have port clk, input, 1, meaning the only clock.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port flash, input, 1, meaning invalidate all lines.
REQ-007 SHALL have port valid, input, 1, meaning fetch request.
REQ-008 SHALL have port addr, input, 32, meaning fetch byte address (word aligned).
REQ-009 SHALL have port ready, output, 1, meaning rdata is valid for addr this cycle.
REQ-010 SHALL have port rdata, output, 32, meaning fetched instruction word.
REQ-011 SHALL have port m_axi, axi_lite_if.master, meaning refill bus.

Function
REQ-012 SHALL be direct-mapped: offset = addr[log2(LINE_WORDS)+1:2], index = next log2(CACHE_SIZE/(4*LINE_WORDS)) bits, tag = remaining upper bits.
REQ-013 SHALL assert ready combinationally, and drive rdata from the stored line word, when valid, the indexed line is valid, tag matches, state is IDLE and flash is low.
REQ-014 SHALL hold rdata at 0 and ready at 0 whenever the hit condition is false.
REQ-015 SHALL use states IDLE, RADDR, RDATA, ALLOCATE; IDLE->RADDR on valid && miss && !flash, latching the line base address (addr with offset bits cleared).
REQ-016 SHALL, in RADDR, drive arvalid=1 and araddr = base + 4*beat, holding both stable until arready; RADDR->RDATA on arvalid && arready.
REQ-017 SHALL, in RDATA, drive rready=1, write rdata into word [beat] of the line on rvalid && rready, then go to RADDR with beat+1, or to ALLOCATE after beat LINE_WORDS-1.
REQ-018 SHALL, in ALLOCATE, write the latched tag, set the line valid bit, clear beat, and return to IDLE; the repeated request hits in the following cycle.
REQ-019 SHALL have a hit latency of 0 cycles and a miss penalty of 2*LINE_WORDS+1 cycles plus bus wait states.
REQ-020 SHALL complete a started refill regardless of later changes to valid or addr, using only the latched base address.
REQ-021 SHALL clear all valid bits on the cycle after flash is sampled high in IDLE.
REQ-022 SHALL, if flash is seen at any point during a refill, finish the bus transfers but not set the line valid bit in ALLOCATE; pending-flush is cleared on return to IDLE.
REQ-023 SHALL tie awvalid, wvalid, bready to 0 and awaddr, wdata, wstrb to 0 permanently.
REQ-024 SHALL drive araddr to 0 outside RADDR and rready to 0 outside RDATA.

Reset
REQ-025 SHALL on rst_n low, asynchronously: state=IDLE, beat=0, all valid bits=0, pending-flush=0, ready=0, arvalid=0, rready=0, araddr=0.
REQ-026 SHALL abandon any refill on reset mid-operation; no partial line becomes valid.

Configuration
REQ-027 SHALL, with macro ICACHE_STATS_EN defined, add output ports hit_cnt and miss_cnt (32 bits each), reset to 0, incremented once per hit cycle and once per IDLE->RADDR transition, wrapping 0xFFFFFFFF->0, cleared by flash.
REQ-028 SHALL, without ICACHE_STATS_EN, have neither port nor counter logic; all other behaviour is unchanged.

Verification
REQ-029 Cold miss: reset, valid, addr=0x100, LINE_WORDS=4 -> ARs at 0x100,0x104,0x108,0x10C; ready=1 with memory word 0x100 on the cycle after ALLOCATE.
REQ-030 Line hit: after REQ-029, addr=0x10C -> ready=1 in the same cycle, no arvalid.
REQ-031 Conflict: addr=0x100 + CACHE_SIZE -> miss, refill evicts; a following 0x100 misses again.
REQ-032 Backpressure: arready held low 5 cycles, rvalid delayed 3 cycles -> araddr stable, no beat skipped, line correct.
REQ-033 Flush during refill: flash pulsed in beat 2 -> 4 beats complete, line invalid, the re-request misses.
REQ-034 Reset mid-refill, then stats: rst_n low in RDATA -> IDLE, ready=0; with ICACHE_STATS_EN, 1 miss + 3 hits -> miss_cnt=1, hit_cnt=3.
